am2928_bus_xcvr: RTL and testbench

- Registered, inverting, bidirectional bus transceiver of WIDTH bits, modelled on the Am2928 bit-slice transceiver.
- A driver register feeds the active-low bus bus_ through an enabled inverting tristate buffer.
- A receiver register captures the inverted bus and presents it on tristate output y.
- The driver register loads from either the d input or the receiver register.
- Used between a CPU datapath (d/y side) and a shared active-low system bus.

---
 rtl/am2928_bus_xcvr.sv | 76 +++++++
 tb/tb_am2928_bus_xcvr.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/am2928_bus_xcvr.sv
// am2928_bus_xcvr: registered, inverting, bidirectional bus transceiver (Am2928 style).
//   A driver register feeds the active-low bus through an inverting tristate buffer.
//   A receiver register captures the inverted bus and presents it on tristate output y.
//   Latency: d -> bus_ one cp edge after load; bus_ -> y one cp edge after load.
//   Output enables (be_, oe_) act combinationally with no clock latency.
//   There is no flow control: every enabled edge loads unconditionally.
// Ports:
//   cp      clock, all register updates on its rising edge
//   rst_    synchronous active-low reset; clears both registers and wins over the load enables
//   d       driver data input
//   s       driver source select: 0 = d, 1 = receiver register
//   endr_   driver register load enable (active low)
//   be_     bus drive enable (active low)
//   enrec_  receiver register load enable (active low)
//   oe_     y output enable (active low)
//   y       receiver register contents, tristate
//   bus_    active-low system bus, bidirectional
//   par     (only with `define AM2928_PARITY_EN) XOR-reduction of the receiver register,
//           always driven and never tristated
module am2928_bus_xcvr #(
  parameter int WIDTH = 4
) (
  input  logic             cp,
  input  logic             rst_,
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             endr_,
  input  logic             be_,
  input  logic             enrec_,
  input  logic             oe_,
  output logic [WIDTH-1:0] y,
`ifdef AM2928_PARITY_EN
  output logic             par,
`endif
  inout  wire  [WIDTH-1:0] bus_
);

  logic [WIDTH-1:0] drv_q, drv_d;
  logic [WIDTH-1:0] rec_q, rec_d;

  // Both registers compute from pre-edge state, so a driver load from the
  // receiver in the same edge as a receiver capture sees the old receiver value.
  always_comb begin
    drv_d = drv_q;
    if (!endr_) begin
      drv_d = s ? rec_q : d;
    end
  end

  // The receiver samples the resolved bus net, so with be_ low it reads back
  // its own driver (loopback) and stores ~(~drv) = drv.
  always_comb begin
    rec_d = rec_q;
    if (!enrec_) begin
      rec_d = ~bus_;
    end
  end

  always_ff @(posedge cp) begin
    if (!rst_) begin
      drv_q <= '0;
      rec_q <= '0;
    end else begin
      drv_q <= drv_d;
      rec_q <= rec_d;
    end
  end

  assign bus_ = be_ ? {WIDTH{1'bz}} : ~drv_q;
  assign y    = oe_ ? {WIDTH{1'bz}} : rec_q;

`ifdef AM2928_PARITY_EN
  assign par = ^rec_q;
`endif

endmodule

// File: tb/tb_am2928_bus_xcvr.sv
// tb_am2928_bus_xcvr: directed scenarios followed by randomized cycles checked
// against a behavioural model of the two registers. High-Z on y / bus_ is
// observed by weakly driving a known pattern from the bench side while the DUT
// is disabled and reading it back unchanged.
module tb_am2928_bus_xcvr;

  logic       cp = 1'b0;
  logic       rst_ = 1'b0;
  logic [3:0] d = '0;
  logic       s = 1'b0;
  logic       endr_ = 1'b1;
  logic       be_ = 1'b1;
  logic       enrec_ = 1'b1;
  logic       oe_ = 1'b1;

  wire  [3:0] y_w;
  wire  [3:0] bus_w;
  logic       ext_en = 1'b0;
  logic [3:0] ext_val = '0;
  logic       prb_en = 1'b0;
  logic [3:0] prb_val = '0;

  assign bus_w = ext_en ? ext_val : 4'bzzzz;
  assign y_w   = prb_en ? prb_val : 4'bzzzz;

`ifdef AM2928_PARITY_EN
  wire par;
`endif

  am2928_bus_xcvr #(.WIDTH(4)) dut (
    .cp     (cp),
    .rst_   (rst_),
    .d      (d),
    .s      (s),
    .endr_  (endr_),
    .be_    (be_),
    .enrec_ (enrec_),
    .oe_    (oe_),
    .y      (y_w),
`ifdef AM2928_PARITY_EN
    .par    (par),
`endif
    .bus_   (bus_w)
  );

  always #5 cp = ~cp;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // advance past the next rising edge, then settle
  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  // behavioural model state
  logic [3:0] drv_m, rec_m, bus_m, y_m;

  initial begin
    // ---- reset ----
    rst_ = 1'b0; endr_ = 1'b0; enrec_ = 1'b0; be_ = 1'b0; oe_ = 1'b0; d = 4'b1111;
    tick(); tick();
    rst_ = 1'b1; endr_ = 1'b1; enrec_ = 1'b1;
    #1;
    chk("reset_bus", bus_w, 4'b1111);
    chk("reset_y", y_w, 4'b0000);
`ifdef AM2928_PARITY_EN
    chk("reset_par", {3'b0, par}, 4'b0000);
`endif

    // ---- outputs high-Z when disabled ----
    oe_ = 1'b1; prb_en = 1'b1; prb_val = 4'b1001;
    be_ = 1'b1; ext_en = 1'b1; ext_val = 4'b0110;
    #1;
    chk("y_hiz", y_w, 4'b1001);
    chk("bus_hiz", bus_w, 4'b0110);
    prb_en = 1'b0; ext_en = 1'b0;

    // ---- driver load and hold ----
    d = 4'b1010; s = 1'b0; endr_ = 1'b0; be_ = 1'b0; oe_ = 1'b0;
    tick();
    chk("drv_load", bus_w, 4'b0101);
    endr_ = 1'b1; d = 4'bxxxx;
    tick();
    chk("drv_hold", bus_w, 4'b0101);

    // ---- receiver load and hold ----
    be_ = 1'b1; ext_en = 1'b1; ext_val = 4'b1011; enrec_ = 1'b0; oe_ = 1'b0;
    tick();
    chk("rec_load1", y_w, 4'b0100);
    ext_val = 4'b1101;
    tick();
    chk("rec_load2", y_w, 4'b0010);
    enrec_ = 1'b1; ext_val = 4'b0000;
    tick();
    chk("rec_hold", y_w, 4'b0010);
    ext_en = 1'b0;

    // ---- receiver to driver ----
    s = 1'b1; endr_ = 1'b0; be_ = 1'b1;
    tick();
    endr_ = 1'b1; be_ = 1'b0;
    #1;
    chk("r2d_bus", bus_w, 4'b1101);
    chk("r2d_y", y_w, 4'b0010);
    d = 4'b0000; s = 1'b0; endr_ = 1'b0;
    tick();
    chk("d0_bus", bus_w, 4'b1111);
    chk("d0_y", y_w, 4'b0010);

    // ---- reset overrides loaded state and load enables ----
    d = 4'b1010; s = 1'b0; endr_ = 1'b0;
    be_ = 1'b1; ext_en = 1'b1; ext_val = 4'b1011; enrec_ = 1'b0;
    tick();
    ext_en = 1'b0; be_ = 1'b0; endr_ = 1'b1; enrec_ = 1'b1;
    #1;
    chk("pre_rst_bus", bus_w, 4'b0101);
    chk("pre_rst_y", y_w, 4'b0100);
    rst_ = 1'b0; endr_ = 1'b0; enrec_ = 1'b0; d = 4'b0110; s = 1'b0;
    tick();
    rst_ = 1'b1; endr_ = 1'b1; enrec_ = 1'b1;
    #1;
    chk("rst_bus", bus_w, 4'b1111);
    chk("rst_y", y_w, 4'b0000);

    // ---- simultaneous update: rec=0011, drv=0101 first ----
    d = 4'b0101; s = 1'b0; endr_ = 1'b0;
    be_ = 1'b1; ext_en = 1'b1; ext_val = 4'b1100; enrec_ = 1'b0;
    tick();
    s = 1'b1; endr_ = 1'b0; enrec_ = 1'b0; ext_val = 4'b1000;
    tick();
    ext_en = 1'b0; endr_ = 1'b1; enrec_ = 1'b1; be_ = 1'b0; oe_ = 1'b0;
    #1;
    chk("simul_drv", bus_w, 4'b1100);
    chk("simul_rec", y_w, 4'b0111);
`ifdef AM2928_PARITY_EN
    chk("simul_par", {3'b0, par}, 4'b0001);
`endif

    // ---- enables act without a clock ----
    be_ = 1'b1; ext_en = 1'b1; ext_val = 4'b0001;
    #1;
    chk("be_off", bus_w, 4'b0001);
    ext_en = 1'b0; be_ = 1'b0;
    #1;
    chk("be_on", bus_w, 4'b1100);

    // ---- loopback: rec captures drv ----
    enrec_ = 1'b0;
    tick();
    enrec_ = 1'b1;
    #1;
    chk("loopback", y_w, 4'b0011);

    // ---- randomized cycles against the model ----
    rst_ = 1'b0;
    tick();
    drv_m = '0; rec_m = '0;
    for (int i = 0; i < 300; i++) begin
      rst_    = ($urandom_range(0, 15) != 0);
      d       = 4'($urandom);
      s       = 1'($urandom);
      endr_   = 1'($urandom);
      be_     = 1'($urandom);
      enrec_  = 1'($urandom);
      oe_     = 1'($urandom);
      ext_val = 4'($urandom);
      prb_val = 4'($urandom);
      ext_en  = be_;
      prb_en  = oe_;
      #1;
      bus_m = be_ ? ext_val : ~drv_m;
      y_m   = oe_ ? prb_val : rec_m;
      chk("rnd_bus", bus_w, bus_m);
      chk("rnd_y", y_w, y_m);
`ifdef AM2928_PARITY_EN
      chk("rnd_par", {3'b0, par}, {3'b0, ^rec_m});
`endif
      // next state, both from pre-edge values
      if (!rst_) begin
        drv_m = '0;
        rec_m = '0;
      end else begin
        logic [3:0] old_rec;
        old_rec = rec_m;
        if (!enrec_) rec_m = ~bus_m;
        if (!endr_) drv_m = s ? old_rec : d;
      end
      tick();
    end
    ext_en = 1'b0; prb_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
